sort_result_store: RTL and testbench



---
 rtl/sorter_pkg.sv | 24 ++
 rtl/sync_edge_detect.sv | 35 +++
 rtl/sort_result_store.sv | 124 ++++++++++++
 tb/tb_sort_result_store.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared definitions for the sorter result path: default value width,
// the stored result record and pointer/count width helpers.
package sorter_pkg;

    localparam int SORT_W = 4;

    // One captured sorter result at the default value width.
    typedef struct packed {
        logic [SORT_W-1:0] largest;
        logic [SORT_W-1:0] second;
        logic              order_err;
    } sort_entry_t;

    // Pointer width for a buffer of the given depth (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: must be able to hold the value depth itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a rising-edge detector producing a
// single-cycle pulse. A level that is already high when reset releases is
// not reported: the detector only arms after it has seen a genuine low.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic [1:0] sync_reg;
    logic [1:0] fill_reg;
    logic       edge_reg;
    logic       armed_reg;

    // Synchronizer chain, previous-value flop and arming logic. fill_reg
    // marks which synchronizer stages hold real samples rather than reset
    // values, so a reset-value zero cannot arm the detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg  <= 2'b00;
            fill_reg  <= 2'b00;
            edge_reg  <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], din};
            fill_reg  <= {fill_reg[0], 1'b1};
            edge_reg  <= sync_reg[1];
            armed_reg <= armed_reg | (fill_reg[1] & ~sync_reg[1]);
        end
    end

    assign pulse = sync_reg[1] & ~edge_reg & armed_reg;

endmodule

// File: rtl/sort_result_store.sv
// Captures (largest, second) pairs from the sorter on each rising edge of
// its asynchronous load level into a circular history buffer, and presents
// the oldest entry to a downstream reader over valid/ready. When full, a new
// write without a coincident pop overwrites the oldest entry and sets the
// sticky overflow flag.
module sort_result_store
    import sorter_pkg::*;
#(
    parameter int W     = SORT_W,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [W-1:0]              largest,
    input  logic [W-1:0]              second,
    input  logic                      clear,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [W-1:0]              rd_largest,
    output logic [W-1:0]              rd_second,
    output logic                      rd_order_err,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    typedef struct packed {
        logic [W-1:0] largest;
        logic [W-1:0] second;
        logic         order_err;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;

    logic          wr_pulse;
    logic          wr;
    logic          pop;
    logic          full;

    sync_edge_detect u_sync_edge_detect (
        .clk   (clk),
        .rst   (rst),
        .din   (load),
        .pulse (wr_pulse)
    );

    assign full     = (count_reg == CW'(DEPTH));
    assign rd_valid = (count_reg != '0);
    assign pop      = rd_valid & rd_ready;
    // A clear in the same cycle as a write pulse drops the write.
    assign wr       = wr_pulse & ~clear;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (clear) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end else begin
            if (wr) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (wr && full && !pop) begin
                // Overwrite the oldest entry: the head moves past it.
                rd_ptr_next   = rd_ptr_reg + PW'(1);
                overflow_next = 1'b1;
            end else if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            if (wr && !pop && !full) begin
                count_next = count_reg + CW'(1);
            end else if (pop && !wr) begin
                count_next = count_reg - CW'(1);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Entry storage; contents are deliberately not reset, validity comes
    // from the occupancy count.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr_reg] <= '{largest:   largest,
                                 second:    second,
                                 order_err: (second > largest)};
        end
    end

    assign head         = mem[rd_ptr_reg];
    assign rd_largest   = rd_valid ? head.largest   : '0;
    assign rd_second    = rd_valid ? head.second    : '0;
    assign rd_order_err = rd_valid ? head.order_err : 1'b0;
    assign count        = count_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_sort_result_store.sv
// Self-checking bench for sort_result_store: table-driven write vectors,
// a queue scoreboard of expected buffer contents, and hand-written
// sequences for latency, same-cycle write/pop, clear and mid-stream reset.
module tb_sort_result_store;
    import sorter_pkg::*;

    localparam int W     = SORT_W;
    localparam int DEPTH = 4;
    localparam int CW    = cnt_w(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [W-1:0]  largest;
    logic [W-1:0]  second;
    logic          clear;
    logic          rd_ready;
    logic          rd_valid;
    logic [W-1:0]  rd_largest;
    logic [W-1:0]  rd_second;
    logic          rd_order_err;
    logic [CW-1:0] count;
    logic          overflow;

    sort_result_store #(.W(W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .largest      (largest),
        .second       (second),
        .clear        (clear),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_largest   (rd_largest),
        .rd_second    (rd_second),
        .rd_order_err (rd_order_err),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] s;
        logic         exp_err;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    sort_entry_t model_q[$];
    logic        exp_ovf = 1'b0;
    vec_t        vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_model(input logic [W-1:0] l, input logic [W-1:0] s, input logic err);
        sort_entry_t e;
        e.largest   = l;
        e.second    = s;
        e.order_err = err;
        model_q.push_back(e);
        if (model_q.size() > DEPTH) begin
            void'(model_q.pop_front());
            exp_ovf = 1'b1;
        end
    endtask

    // Called at a negedge: compares all outputs with the scoreboard.
    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(model_q.size()));
        chk({tag, "_valid"}, 32'(rd_valid), 32'(model_q.size() != 0));
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        if (model_q.size() != 0) begin
            chk({tag, "_largest"}, 32'(rd_largest), 32'(model_q[0].largest));
            chk({tag, "_second"}, 32'(rd_second), 32'(model_q[0].second));
            chk({tag, "_err"}, 32'(rd_order_err), 32'(model_q[0].order_err));
        end else begin
            chk({tag, "_largest0"}, 32'(rd_largest), 32'd0);
            chk({tag, "_second0"}, 32'(rd_second), 32'd0);
            chk({tag, "_err0"}, 32'(rd_order_err), 32'd0);
        end
        $display("[TB] %s: count=%0d valid=%0b head=%0d/%0d err=%0b ovf=%0b",
                 tag, count, rd_valid, rd_largest, rd_second, rd_order_err, overflow);
    endtask

    // Called at a negedge with load low; leaves the bench at a negedge.
    task automatic do_write(input logic [W-1:0] l, input logic [W-1:0] s,
                            input logic err, input int hold);
        largest = l;
        second  = s;
        #2 load = 1'b1;
        repeat (hold) @(negedge clk);
        load = 1'b0;
        push_model(l, s, err);
        repeat (4) @(negedge clk);
        $display("[TB] write %0d/%0d hold=%0d -> count=%0d", l, s, hold, count);
    endtask

    // Back-to-back pops, checking the head before each accepting edge.
    task automatic pop_n(input string tag, input int n);
        rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_pop_valid"}, 32'(rd_valid), 32'd1);
            chk({tag, "_pop_largest"}, 32'(rd_largest), 32'(model_q[0].largest));
            chk({tag, "_pop_second"}, 32'(rd_second), 32'(model_q[0].second));
            $display("[TB] %s pop %0d: %0d/%0d err=%0b", tag, i, rd_largest, rd_second, rd_order_err);
            @(negedge clk);
            void'(model_q.pop_front());
        end
        rd_ready = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_q.delete();
        exp_ovf = 1'b0;
    endtask

    initial begin
        vecs[0] = '{l: 4'd15, s: 4'd14, exp_err: 1'b0};
        vecs[1] = '{l: 4'd12, s: 4'd3,  exp_err: 1'b0};
        vecs[2] = '{l: 4'd7,  s: 4'd7,  exp_err: 1'b0};
        vecs[3] = '{l: 4'd2,  s: 4'd1,  exp_err: 1'b0};
        vecs[4] = '{l: 4'd8,  s: 4'd6,  exp_err: 1'b0};

        rst = 1'b1; load = 1'b0; clear = 1'b0; rd_ready = 1'b0;
        largest = '0; second = '0;
        repeat (3) @(negedge clk);
        check_state("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Write latency: rise before edge N, write lands at edge N+2.
        largest = 4'd9; second = 4'd5;
        #2 load = 1'b1;
        @(posedge clk); #1 chk("lat_edgeN", 32'(count), 32'd0);
        @(posedge clk); #1 chk("lat_edgeN1", 32'(count), 32'd0);
        @(posedge clk); #1 chk("lat_edgeN2", 32'(count), 32'd1);
        repeat (3) @(negedge clk);
        load = 1'b0;
        push_model(4'd9, 4'd5, 1'b0);
        repeat (4) @(negedge clk);
        check_state("first");
        pop_n("first", 1);
        check_state("first_empty");

        // Five writes into four slots: oldest is overwritten.
        for (int i = 0; i < 5; i++) do_write(vecs[i].l, vecs[i].s, vecs[i].exp_err, 4);
        check_state("wrap");
        chk("wrap_head_is_12", 32'(rd_largest), 32'd12);
        pop_n("wrap", 4);
        check_state("wrap_empty");

        // Order error flag.
        do_clear();
        check_state("clear1");
        do_write(4'd3, 4'd10, 1'b1, 4);
        check_state("order_err");

        // Fill, then write while popping in the pulse cycle.
        for (int i = 0; i < 3; i++) do_write(vecs[i].l, vecs[i].s, vecs[i].exp_err, 4);
        check_state("full");
        largest = 4'd11; second = 4'd4;
        #2 load = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rd_ready = 1'b1;
        chk("wp_head_before", 32'(rd_largest), 32'(model_q[0].largest));
        @(posedge clk);
        #1 rd_ready = 1'b0;
        void'(model_q.pop_front());
        push_model(4'd11, 4'd4, 1'b0);
        repeat (2) @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        check_state("write_pop_full");

        // Long load level: one write only; then clear.
        do_clear();
        do_write(4'd5, 4'd2, 1'b0, 20);
        check_state("long_load");
        do_clear();
        check_state("clear2");

        // Reset mid-stream with load high and a write pending.
        do_write(4'd1, 4'd0, 1'b0, 4);
        do_write(4'd14, 4'd9, 1'b0, 4);
        check_state("pre_rst");
        largest = 4'd6; second = 4'd1;
        #2 load = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_largest", 32'(rd_largest), 32'd0);
        model_q.delete();
        exp_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_state("post_rst_load_high");
        load = 1'b0;
        repeat (4) @(negedge clk);
        do_write(4'd13, 4'd12, 1'b0, 4);
        check_state("post_rst_write");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
